// File: rtl/dmem_responder.sv
// Word-addressed, byte-strobed data memory answering one load/store at a time
// over valid/ready handshakes, with a fixed access latency to emulate slow memory.
module dmem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int WORDSIZE  = 64,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [WORDSIZE-1:0]   req_wdata,
    input  logic [WORDSIZE/8-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORDSIZE-1:0]   rsp_rdata,
    output logic                  rsp_we,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int LANES = WORDSIZE / 8;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic                   we_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [WORDSIZE-1:0]    wdata_q;
    logic [LANES-1:0]       wstrb_q;
    logic [WORDSIZE-1:0]    mem [DEPTH];
    logic [WORDSIZE-1:0]    merged;

    // Post-write word: strobed lanes from the request, the rest from storage.
    always_comb begin
        merged = mem[addr_q];
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_we    <= 1'b0;
            count     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        count     <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        if (we_q) begin
                            mem[addr_q] <= merged;
                            rsp_rdata   <= merged;
                        end else begin
                            rsp_rdata   <= mem[addr_q];
                        end
                        rsp_we    <= we_q;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for the minimum-latency case.
module tb_dmem_responder;

    typedef struct {
        logic [63:0] rdata;
        logic        we;
    } exp_t;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_we, busy;
    logic [63:0] rsp_rdata;

    logic        req_valid_1 = 1'b0;
    logic        rsp_ready_1 = 1'b1;
    logic        req_ready_1, rsp_valid_1, rsp_we_1, busy_1;
    logic [63:0] rsp_rdata_1;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(6), .WORDSIZE(64), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_we(rsp_we), .busy(busy)
    );

    dmem_responder #(.ADDR_BITS(6), .WORDSIZE(64), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1),
        .rsp_we(rsp_we_1), .busy(busy_1)
    );

    // Drives one request into dut; returns the response and edges from acceptance
    // to rsp_valid. Consumes the response only if rsp_ready is already high.
    task automatic drive(input logic we, input logic [5:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wstrb, output logic [63:0] rdata,
                         output logic rwe, output int lat, output bit timeout);
        timeout   = 1'b0;
        lat       = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) timeout = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) timeout = 1'b1;
        rdata = rsp_rdata;
        rwe   = rsp_we;
        if (rsp_ready && rsp_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_we, busy} !== 4'b1000 || rsp_rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL reset: ready/valid/we/busy=%b rdata=%h, required 1000 rdata=0",
                     {req_ready, rsp_valid, rsp_we, busy}, rsp_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_latency();
        logic [63:0] rdata; logic rwe; int lat; bit to; exp_t e;
        sb.push_back('{64'h0, 1'b0});
        drive(1'b0, 6'd5, 64'h0, 8'h00, rdata, rwe, lat, to);
        e = sb.pop_front();
        vectors++;
        if (to !== 1'b0 || rdata !== e.rdata || rwe !== e.we || lat != 2) begin
            miscompares++;
            $display("FAIL load_latency: rdata=%h we=%b lat=%0d timeout=%0b, required rdata=%h we=%b lat=2",
                     rdata, rwe, lat, to, e.rdata, e.we);
        end
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_release: req_ready=%b rsp_valid=%b busy=%b, required 1 0 0",
                     req_ready, rsp_valid, busy);
        end
    endtask

    task automatic test_store_strobes();
        vec_t v[6];
        logic [63:0] rdata; logic rwe; int lat; bit to; exp_t e;
        v[0] = '{1'b1, 6'd3, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF};
        v[1] = '{1'b0, 6'd3, 64'h0, 8'h00, 64'h0123456789ABCDEF};
        v[2] = '{1'b1, 6'd3, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h01234567FFFFFFFF};
        v[3] = '{1'b0, 6'd3, 64'h0, 8'h00, 64'h01234567FFFFFFFF};
        v[4] = '{1'b1, 6'd3, 64'h0000000000000000, 8'h00, 64'h01234567FFFFFFFF};
        v[5] = '{1'b0, 6'd3, 64'h0, 8'h00, 64'h01234567FFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{v[i].exp, v[i].we});
            drive(v[i].we, v[i].addr, v[i].wdata, v[i].wstrb, rdata, rwe, lat, to);
            e = sb.pop_front();
            vectors++;
            if (to !== 1'b0 || rdata !== e.rdata || rwe !== e.we || lat != 2) begin
                miscompares++;
                $display("FAIL store_strobes[%0d]: rdata=%h we=%b lat=%0d timeout=%0b, required rdata=%h we=%b lat=2",
                         i, rdata, rwe, lat, to, e.rdata, e.we);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rdata; logic rwe; int lat; bit to; exp_t e;
        rsp_ready = 1'b0;
        sb.push_back('{64'h01234567FFFFFFFF, 1'b0});
        drive(1'b0, 6'd3, 64'h0, 8'h00, rdata, rwe, lat, to);
        e = sb.pop_front();
        vectors++;
        if (to !== 1'b0 || rdata !== e.rdata || rwe !== e.we) begin
            miscompares++;
            $display("FAIL backpressure_rsp: rdata=%h we=%b timeout=%0b, required rdata=%h we=%b",
                     rdata, rwe, to, e.rdata, e.we);
        end
        // A competing store presented while the response is stalled must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd4;
        req_wdata = 64'h5555555555555555; req_wstrb = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({rsp_valid, req_ready, busy} !== 3'b101 || rsp_rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: valid/ready/busy=%b rdata=%h, required 101 rdata=%h",
                         i, {rsp_valid, req_ready, busy}, rsp_rdata, e.rdata);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: rsp_valid=%b req_ready=%b, required 0 1",
                     rsp_valid, req_ready);
        end
        sb.push_back('{64'h0, 1'b0});
        drive(1'b0, 6'd4, 64'h0, 8'h00, rdata, rwe, lat, to);
        e = sb.pop_front();
        vectors++;
        if (to !== 1'b0 || rdata !== e.rdata || rwe !== e.we) begin
            miscompares++;
            $display("FAIL ignored_store: rdata=%h we=%b timeout=%0b, required rdata=%h we=%b",
                     rdata, rwe, to, e.rdata, e.we);
        end
    endtask

    task automatic test_boundaries();
        vec_t v[4];
        logic [63:0] rdata; logic rwe; int lat; bit to; exp_t e;
        v[0] = '{1'b1, 6'd63, 64'h1111, 8'hFF, 64'h1111};
        v[1] = '{1'b1, 6'd0,  64'h2222, 8'hFF, 64'h2222};
        v[2] = '{1'b0, 6'd63, 64'h0,    8'h00, 64'h1111};
        v[3] = '{1'b0, 6'd0,  64'h0,    8'h00, 64'h2222};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{v[i].exp, v[i].we});
            drive(v[i].we, v[i].addr, v[i].wdata, v[i].wstrb, rdata, rwe, lat, to);
            e = sb.pop_front();
            vectors++;
            if (to !== 1'b0 || rdata !== e.rdata || rwe !== e.we || lat != 2) begin
                miscompares++;
                $display("FAIL boundaries[%0d]: rdata=%h we=%b lat=%0d timeout=%0b, required rdata=%h we=%b lat=2",
                         i, rdata, rwe, lat, to, e.rdata, e.we);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t v[2];
        logic [63:0] rdata; logic rwe; int lat; bit to; exp_t e;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7;
        req_wdata = 64'hAA; req_wstrb = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({req_ready, rsp_valid, rsp_we, busy} !== 4'b1000 || rsp_rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_mid: ready/valid/we/busy=%b rdata=%h, required 1000 rdata=0",
                     {req_ready, rsp_valid, rsp_we, busy}, rsp_rdata);
        end
        // Address 3 held a nonzero word before reset; reset clears storage.
        v[0] = '{1'b0, 6'd7, 64'h0, 8'h00, 64'h0};
        v[1] = '{1'b0, 6'd3, 64'h0, 8'h00, 64'h0};
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{v[i].exp, v[i].we});
            drive(v[i].we, v[i].addr, v[i].wdata, v[i].wstrb, rdata, rwe, lat, to);
            e = sb.pop_front();
            vectors++;
            if (to !== 1'b0 || rdata !== e.rdata || rwe !== e.we) begin
                miscompares++;
                $display("FAIL reset_mid_load[%0d]: rdata=%h we=%b timeout=%0b, required rdata=%h we=%b",
                         i, rdata, rwe, to, e.rdata, e.we);
            end
        end
    endtask

    task automatic test_latency1();
        vec_t v[2];
        int lat; exp_t e;
        v[0] = '{1'b1, 6'd9, 64'h3333, 8'hFF, 64'h3333};
        v[1] = '{1'b0, 6'd9, 64'h0,    8'h00, 64'h3333};
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{v[i].exp, v[i].we});
            req_we = v[i].we; req_addr = v[i].addr;
            req_wdata = v[i].wdata; req_wstrb = v[i].wstrb;
            req_valid_1 = 1'b1;
            lat = 0;
            @(posedge clk); #1;
            req_valid_1 = 1'b0;
            while (!rsp_valid_1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            e = sb.pop_front();
            vectors++;
            if (rsp_valid_1 !== 1'b1 || lat != 1 || rsp_rdata_1 !== e.rdata || rsp_we_1 !== e.we) begin
                miscompares++;
                $display("FAIL latency1[%0d]: valid=%b lat=%0d rdata=%h we=%b, required valid=1 lat=1 rdata=%h we=%b",
                         i, rsp_valid_1, lat, rsp_rdata_1, rsp_we_1, e.rdata, e.we);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_store_strobes();
        test_backpressure();
        test_boundaries();
        test_reset_mid();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder (memory) end of the processor's data-memory interface: a word-addressed, byte-strobed data store serving one load/store request at a time over a valid/ready handshake.
- Configurable fixed access latency emulates slow memory, so the core's stall logic can be exercised.
- Sits opposite the processor's data port in processor-level benches and in the SoC top.

Parameters:
ADDR_BITS, 6, word-address width; depth = 2^ADDR_BITS words
WORDSIZE, 64, data word width in bits (multiple of 8)
LATENCY, 2, cycles from request acceptance to response valid (>=1)

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  reset, synchronous, active-high
req_valid  input  1  requester presents a request
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_BITS  word address
req_wdata  input  WORDSIZE  store data
req_wstrb  input  WORDSIZE/8  byte-lane write enables (bit i -> bits 8i+7:8i)
rsp_valid  output  1  response available
rsp_ready  input  1  requester consumes response
rsp_rdata  output  WORDSIZE  load data, or post-write word for stores
rsp_we  output  1  echo of req_we of the request being answered
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (rst high at a rising edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_we=0, busy=0, latency counter=0.
  - Every memory word is cleared to 0.
  - Reset overrides all other events in that cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid && req_ready: latch we/addr/wdata/wstrb, counter <= LATENCY-1, req_ready <= 0, go to WAIT.
- WAIT:
  - While counter != 0, decrement it each edge.
  - On the edge where counter == 0, perform the access:
    - Store: mem[addr] lanes with wstrb=1 take wdata; other lanes unchanged. rsp_rdata <= resulting word.
    - Load: rsp_rdata <= mem[addr].
  - On that same edge: rsp_we <= latched we, rsp_valid <= 1, go to RESP.
- Latency: request accepted at edge N -> rsp_valid first high after edge N+LATENCY.
- RESP:
  - rsp_valid, rsp_rdata and rsp_we are held stable until an edge with rsp_ready=1.
  - At that edge: rsp_valid <= 0, req_ready <= 1, go to IDLE. rsp_rdata and rsp_we keep their last value.
- No request is accepted in the same cycle a response is consumed. Peak throughput is one transaction per LATENCY+2 cycles.
- req_valid while req_ready=0 is ignored: not latched, no side effects. The requester must hold the request until accepted.
- Store with wstrb=0: memory unchanged; a response is still issued, with rsp_rdata = current word.
- Reset during WAIT: the pending store is not committed if reset arrives on or before the access edge. Reset during RESP drops the response.
- Addressing: full decode, so every ADDR_BITS value is valid. Addresses 0 and 2^ADDR_BITS-1 are distinct, independent words; there is no aliasing or wrap.
- Read-after-write to the same address in consecutive transactions returns the new data, because storage is updated at the access edge.
- busy is combinationally derived from state; all other outputs are registered.

Test Plan:
- Reset, then load addr 5 (LATENCY=2, rsp_ready=1) -> rsp_valid rises exactly 2 edges after acceptance, rsp_rdata=0, rsp_we=0; req_ready back to 1 one edge later.
- Store addr 3, wdata 0x0123456789ABCDEF, wstrb 0xFF -> store response has rsp_rdata=0x0123456789ABCDEF and rsp_we=1. A following load of addr 3 returns 0x0123456789ABCDEF.
- Then store addr 3, wdata 0xFFFFFFFFFFFFFFFF, wstrb 0x0F -> response and subsequent load both give 0x01234567FFFFFFFF. A store with wstrb=0x00 leaves the word unchanged.
- Backpressure: load addr 3 with rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_rdata stays constant, req_ready=0 and busy=1 throughout. A second req_valid (store addr 4) is ignored, so a later load of addr 4 returns 0.
- Reset mid-operation: store 0xAA to addr 7 (wstrb 0xFF), assert rst during WAIT -> outputs return to reset values next edge. A subsequent load of addr 7 returns 0.
- Boundaries: store 0x1111 to addr 63 and 0x2222 to addr 0 -> loads return 0x1111 and 0x2222 respectively. With LATENCY=1, rsp_valid rises 1 edge after acceptance.
